// File: rtl/divisor_segmentado_param.sv
// Pipelined restoring divider: signed/unsigned per op, BITS_PER_STAGE quotient bits per stage,
// tagged ops, whole-pipe stall from the Done/Done_ack output handshake, Div0 and Ovf flags.
module divisor_segmentado_param #(
    parameter int tamanyo        = 32,
    parameter int BITS_PER_STAGE = 1,
    parameter int TAG_W          = 4
) (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               Start,
    output logic               Ready_in,
    input  logic               Signed_mode,
    input  logic [tamanyo-1:0] Num,
    input  logic [tamanyo-1:0] Den,
    input  logic [TAG_W-1:0]   Tag_in,
    output logic               Done,
    input  logic               Done_ack,
    output logic [tamanyo-1:0] Coc,
    output logic [tamanyo-1:0] Res,
    output logic [TAG_W-1:0]   Tag_out,
    output logic               Div0,
    output logic               Ovf,
    output logic               Busy
);

    // Handshake: an op is accepted on a rising edge with Start && Ready_in; a result is consumed
    // on a rising edge with Done && Done_ack. While Done && !Done_ack the whole pipe holds.

    localparam int N = tamanyo / BITS_PER_STAGE;
    localparam logic [tamanyo-1:0] MIN = {1'b1, {(tamanyo-1){1'b0}}};

    typedef struct packed {
        logic               v;
        logic               q_neg;
        logic               r_neg;
        logic               div0;
        logic               ovf;
        logic [TAG_W-1:0]   tag;
        logic [tamanyo-1:0] r;
        logic [tamanyo-1:0] n;
        logic [tamanyo-1:0] d;
    } stage_t;

    // n starts as |Num| and is shifted left; freed low bits collect the quotient.
    function automatic stage_t step(input stage_t s);
        stage_t           o;
        logic [tamanyo:0] rr;
        o = s;
        for (int k = 0; k < BITS_PER_STAGE; k++) begin
            rr  = {o.r, o.n[tamanyo-1]};
            o.n = {o.n[tamanyo-2:0], 1'b0};
            if (rr >= {1'b0, o.d}) begin
                rr     = rr - {1'b0, o.d};
                o.n[0] = 1'b1;
            end
            o.r = rr[tamanyo-1:0];
        end
        return o;
    endfunction

    stage_t             pipe [0:N];
    stage_t             in_stage;
    logic               enable;
    logic               num_neg;
    logic               den_neg;
    logic [tamanyo-1:0] q_fin;
    logic [tamanyo-1:0] r_fin;
    logic               any_valid;

    assign enable   = !(Done && !Done_ack);
    assign Ready_in = enable;

    always_comb begin
        num_neg        = Signed_mode & Num[tamanyo-1];
        den_neg        = Signed_mode & Den[tamanyo-1];
        in_stage       = '0;
        in_stage.v     = Start;
        in_stage.q_neg = num_neg ^ den_neg;
        in_stage.r_neg = num_neg;
        in_stage.div0  = (Den == '0);
        in_stage.ovf   = Signed_mode && (Num == MIN) && (Den == '1);
        in_stage.tag   = Tag_in;
        in_stage.n     = num_neg ? -Num : Num;
        in_stage.d     = den_neg ? -Den : Den;
    end

    // Den==0 leaves r = |Num|, so sign correction already restores Res = Num; only Coc is forced.
    always_comb begin
        q_fin = pipe[N].q_neg ? -pipe[N].n : pipe[N].n;
        if (pipe[N].div0) begin
            q_fin = '1;
        end
        r_fin = pipe[N].r_neg ? -pipe[N].r : pipe[N].r;
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            for (int i = 0; i <= N; i++) begin
                pipe[i] <= '0;
            end
            Done    <= 1'b0;
            Coc     <= '0;
            Res     <= '0;
            Tag_out <= '0;
            Div0    <= 1'b0;
            Ovf     <= 1'b0;
        end else if (enable) begin
            pipe[0] <= in_stage;
            for (int i = 1; i <= N; i++) begin
                pipe[i] <= step(pipe[i-1]);
            end
            Done <= pipe[N].v;
            if (pipe[N].v) begin
                Coc     <= q_fin;
                Res     <= r_fin;
                Tag_out <= pipe[N].tag;
                Div0    <= pipe[N].div0;
                Ovf     <= pipe[N].ovf;
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i <= N; i++) begin
            any_valid = any_valid | pipe[i].v;
        end
    end

    assign Busy = any_valid | Done;

endmodule

// File: tb/tb_divisor_segmentado_param.sv
// Bench for divisor_segmentado_param: three instances (B = 1, 2, 4) share one op stream and are
// checked every cycle against an arithmetic model with a timing rule for latency and stall.
module tb_divisor_segmentado_param;

  localparam int W     = 32;
  localparam int TAG_W = 6;

  typedef struct {
    logic [W-1:0]     coc;
    logic [W-1:0]     res;
    logic [TAG_W-1:0] tag;
    logic             div0;
    logic             ovf;
    int               acc;
    int               acc_stall;
  } exp_t;

  logic             clk;
  logic             rsta;
  logic             start;
  logic             smode;
  logic [W-1:0]     num;
  logic [W-1:0]     den;
  logic [TAG_W-1:0] tag_in;
  logic             ack;
  logic [2:0]       ready_v;
  logic [2:0]       busy_v;
  logic             all_ready;

  int               n_checks = 0;
  int               n_pass = 0;
  int               cyc = 0;
  int               hold_cnt = 0;
  bit               rand_ack = 0;
  logic [TAG_W-1:0] tag_ctr = '0;

  assign all_ready = &ready_v;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
  endtask

  // Reference: plain integer division with the flag rules layered on top.
  function automatic exp_t model(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [TAG_W-1:0] t);
    exp_t   e;
    longint sa, sb, q, r;
    e.coc = '0; e.res = '0; e.tag = t; e.div0 = 0; e.ovf = 0; e.acc = 0; e.acc_stall = 0;
    if (b == '0) begin
      e.coc = '1; e.res = a; e.div0 = 1;
    end else if (sm && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.coc = a; e.res = '0; e.ovf = 1;
    end else if (sm) begin
      sa = $signed(a); sb = $signed(b);
      q = sa / sb; r = sa % sb;
      e.coc = q[W-1:0]; e.res = r[W-1:0];
    end else begin
      e.coc = a / b; e.res = a % b;
    end
    return e;
  endfunction

  task automatic pin(input string nm, input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ec, input logic [W-1:0] er, input bit ed, input bit eo);
    exp_t m;
    m = model(sm, a, b, '0);
    check(nm, {m.coc, m.res, m.div0, m.ovf}, {ec, er, ed, eo});
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int BPS = 1 << g;
    localparam int NST = W / BPS;
    logic             ready, done, div0, ovf, busy;
    logic [W-1:0]     coc, res;
    logic [TAG_W-1:0] tag_out;
    exp_t             exp_q[$];
    int               stalls = 0;

    divisor_segmentado_param #(.tamanyo(W), .BITS_PER_STAGE(BPS), .TAG_W(TAG_W)) dut (
      .CLK(clk), .RSTa(rsta), .Start(start && all_ready), .Ready_in(ready),
      .Signed_mode(smode), .Num(num), .Den(den), .Tag_in(tag_in),
      .Done(done), .Done_ack(ack), .Coc(coc), .Res(res), .Tag_out(tag_out),
      .Div0(div0), .Ovf(ovf), .Busy(busy)
    );
    assign ready_v[g] = ready;
    assign busy_v[g]  = busy;

    // Scoreboard: an op accepted on edge acc becomes visible after N+1 further enabled edges,
    // i.e. the accepting edge counts as cycle 1 and the result is valid after cycle N+2.
    always @(negedge clk) begin
      exp_t h;
      int   age;
      bit   done_exp;
      if (!rsta) begin
        check($sformatf("b%0d_reset_outs", BPS), {done, coc, res, tag_out, div0, ovf, busy}, '0);
        exp_q.delete();
      end else begin
        check($sformatf("b%0d_ready", BPS), ready, !(done && !ack));
        check($sformatf("b%0d_busy", BPS), busy, exp_q.size() != 0);
        done_exp = 0;
        if (exp_q.size() != 0) begin
          h = exp_q[0];
          age = cyc - h.acc - (stalls - h.acc_stall);
          done_exp = (age >= NST + 1);
        end
        check($sformatf("b%0d_done", BPS), done, done_exp);
        if (done && exp_q.size() != 0) begin
          h = exp_q[0];
          check($sformatf("b%0d_result", BPS), {coc, res, tag_out, div0, ovf},
                {h.coc, h.res, h.tag, h.div0, h.ovf});
          if (ack) void'(exp_q.pop_front());
        end
        if (done && !ack) stalls++;
        if (start && all_ready) begin
          h = model(smode, num, den, tag_in);
          h.acc = cyc + 1;
          h.acc_stall = stalls;
          exp_q.push_back(h);
        end
      end
    end
  end

  // Done_ack driver: held low for hold_cnt cycles, random when rand_ack, otherwise 1.
  initial begin
    ack = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hold_cnt > 0) begin
        ack = 1'b0;
        hold_cnt--;
      end else if (rand_ack) ack = ($urandom_range(0, 3) != 0);
      else ack = 1'b1;
    end
  end

  // driver tasks: called at posedge+1, return at posedge+1 after the op is accepted
  task automatic send(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b);
    bit took;
    int guard;
    start = 1'b1; smode = sm; num = a; den = b; tag_in = tag_ctr;
    took = 0; guard = 0;
    do begin
      @(negedge clk); took = all_ready;
      @(posedge clk); #1;
      guard++;
    end while (!took && guard < 300);
    if (!took) check("send_timeout", 0, 1);
    start = 1'b0;
    tag_ctr++;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(1, 20));
      4: return -W'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  task automatic rnd_send();
    send(1'($urandom_range(0, 1)), rnd_val(), rnd_val());
  endtask

  initial begin
    int guard;
    rsta = 1'b0; start = 1'b0; smode = 1'b0; num = '0; den = '0; tag_in = '0;

    pin("pin_s_100_7",   1, 32'd100,  32'd7,  32'd14,  32'd2,  0, 0);
    pin("pin_s_m100_7",  1, -32'd100, 32'd7,  -32'd14, -32'd2, 0, 0);
    pin("pin_s_100_m7",  1, 32'd100,  -32'd7, -32'd14, 32'd2,  0, 0);
    pin("pin_s_m100_m7", 1, -32'd100, -32'd7, 32'd14,  -32'd2, 0, 0);
    pin("pin_u_ff_16",   0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 0, 0);
    pin("pin_s_m1_16",   1, 32'hFFFF_FFFF, 32'h10, 32'h0, 32'hFFFF_FFFF, 0, 0);
    pin("pin_div0",      0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1, 0);
    pin("pin_ovf",       1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 0, 1);

    repeat (3) @(posedge clk);
    #1 rsta = 1'b1;
    idle(2);

    // directed vectors
    send(1, 32'd100, 32'd7);  send(1, -32'd100, 32'd7);
    send(1, 32'd100, -32'd7); send(1, -32'd100, -32'd7);
    send(0, 32'hFFFF_FFFF, 32'h10); send(1, 32'hFFFF_FFFF, 32'h10);
    send(0, 32'h1234, 32'h0); send(1, 32'h1234, 32'h0);
    send(1, 32'h8000_0000, 32'hFFFF_FFFF); send(0, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(40);

    // 40 back-to-back ops, tags 0..39
    tag_ctr = '0;
    for (int i = 0; i < 40; i++) rnd_send();
    idle(40);

    // mid-stream stall of 5 cycles
    for (int i = 0; i < 60; i++) begin
      if (i == 45) hold_cnt = 5;
      rnd_send();
    end
    idle(40);

    // random acceptance gaps and random Done_ack
    rand_ack = 1;
    for (int i = 0; i < 150; i++) begin
      rnd_send();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_ack = 0;
    idle(60);

    // reset with 10 ops in flight, then a fresh op
    for (int i = 0; i < 10; i++) rnd_send();
    rsta = 1'b0;
    @(posedge clk); #1;
    rsta = 1'b1;
    idle(5);
    send(1, -32'd77, 32'd5);
    idle(3);

    guard = 0;
    while (busy_v != 3'b000 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_busy", busy_v, 3'b000);
    check("drain_queues", {gen_dut[0].exp_q.size(), gen_dut[1].exp_q.size(),
                           gen_dut[2].exp_q.size()}, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
